// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: bridges single-cycle core data-memory requests onto a slow
// RAM port with a request/ack handshake. A captured request is held in the
// mem_* registers while mem_req_o is high; the core is stalled until the RAM
// acknowledges (or the optional watchdog fires).
//
// Handshake: mem_req_o is high for every cycle the bridge waits on the RAM and
// the mem_we/addr/sel/wdata registers are stable for that whole window; the RAM
// completes the transfer by pulsing mem_ack_i for exactly one cycle while
// mem_req_o is high. Any mem_ack_i seen while mem_req_o is low is ignored.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to add a watchdog that ends a
// stuck request after TIMEOUT_CYCLES waiting cycles, returns 32'hDEAD_BEEF to
// loads and raises the sticky bus_err_o flag.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
`ifdef MEM_BRIDGE_TIMEOUT_EN
  ,
  output logic        bus_err_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject an out-of-range watchdog limit when the design is elaborated.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0] state;
  // Remembers a flush seen in any earlier REQ cycle so the completing ack
  // can still be discarded even if flush_i has dropped by then.
  logic       flush_seen;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  // Compare against limit-1: the counter holds the number of finished
  // waiting cycles, so the limit is reached during the last allowed cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`endif

  // Stall the core while a request is being captured or is outstanding;
  // never stall while reset is asserted.
  always_comb begin
    stallreq_o = 1'b0;
    if (rst) begin
      if (state == S_REQ) begin
        stallreq_o = 1'b1;
      end else if (state == S_IDLE && cpu_ce_i && !flush_i) begin
        stallreq_o = 1'b1;
      end
    end
  end

  assign mem_req_o   = (state == S_REQ);
  assign dbg_state_o = state;

  // Main FSM with request capture, read-data return and flush tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      flush_seen  <= 1'b0;
      cpu_data_o  <= 32'd0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_sel_o   <= 4'd0;
      mem_wdata_o <= 32'd0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      wait_cnt    <= 16'd0;
      bus_err_o   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_sel_o   <= cpu_sel_i;
            mem_wdata_o <= cpu_data_i;
            flush_seen  <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            wait_cnt    <= 16'd0;
`endif
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            // A flushed access still completes on the RAM side, but its
            // result is dropped and the DONE cycle is skipped.
            if (flush_i || flush_seen) begin
              state <= S_IDLE;
            end else begin
              if (!mem_we_o) begin
                cpu_data_o <= mem_rdata_i;
              end
              state <= S_DONE;
            end
            flush_seen <= 1'b0;
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            if (!mem_we_o) begin
              cpu_data_o <= 32'hDEAD_BEEF;
            end
            bus_err_o  <= 1'b1;
            flush_seen <= 1'b0;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (flush_i) begin
              flush_seen <= 1'b1;
            end
          end
`else
          else if (flush_i) begin
            flush_seen <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // cpu_data_i is only meaningful for stores; it is captured above.
  // Nothing else to drive here.

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Testbench for mem_bus_bridge: directed cases plus randomized transactions.
// A driver issues whole transactions and pushes the expected request fields,
// returned data and stall length into queues; a negedge monitor pops and
// compares whenever the DUT presents a request or completes one.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  dbg_state_o;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic        bus_err_o;
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  mem_bus_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .stallreq_o  (stallreq_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_sel_o   (mem_sel_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state_o (dbg_state_o)
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    .bus_err_o   (bus_err_o)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [68:0] req_q[$];   // {we, addr, sel, wdata}
  logic [31:0] exp_q[$];   // cpu_data_o after completion
  int          lat_q[$];   // stall cycles per transaction
  logic [31:0] model_data = 32'd0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one complete transaction starting in an IDLE cycle.
  // n_wait = REQ cycles before the ack cycle; flush_at = REQ cycle index
  // (0..n_wait) carrying a flush pulse, or -1 for none.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input int n_wait, input logic [31:0] rdata,
                        input int flush_at);
    bit flushed;
    flushed = (flush_at >= 0);
    req_q.push_back({we, addr, sel, wdata});
    if (!we && !flushed) model_data = rdata;
    exp_q.push_back(model_data);
    lat_q.push_back(n_wait + 2);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    flush_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    for (int i = 0; i < n_wait; i++) begin
      // Junk core request during REQ must be ignored.
      cpu_ce_i = 1'($urandom_range(0, 1)); cpu_we_i = 1'($urandom_range(0, 1));
      cpu_addr_i = $urandom; cpu_sel_i = 4'($urandom_range(0, 15)); cpu_data_i = $urandom;
      flush_i = (i == flush_at);
      tick();
    end
    cpu_ce_i = 1'b0;
    flush_i = (flush_at == n_wait);
    mem_ack_i = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i = 1'b0;
    flush_i = 1'b0;
    mem_rdata_i = $urandom;
    if (!flushed) begin
      // DONE cycle: ce, flush and stray ack are all ignored here.
      cpu_ce_i = 1'($urandom_range(0, 1)); flush_i = 1'($urandom_range(0, 1));
      mem_ack_i = 1'($urandom_range(0, 1));
    end
    tick();
    cpu_ce_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  // Monitor: pops expectations when the DUT presents or completes a request.
  logic        prev_req = 1'b0;
  logic        prev_done = 1'b0;
  int          stall_cnt = 0;
  logic [68:0] held_req;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_req = 1'b0; prev_done = 1'b0; stall_cnt = 0;
    end else begin
      if (prev_done) begin
        if (exp_q.size() == 0) chk("data_q_underflow", 80'd1, 80'd0);
        else chk("cpu_data", 80'(cpu_data_o), 80'(exp_q.pop_front()));
        chk("req_drop_after_ack", 80'(mem_req_o), 80'd0);
      end
      if (mem_req_o && !prev_req) begin
        held_req = {mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o};
        if (req_q.size() == 0) chk("req_q_underflow", 80'd1, 80'd0);
        else chk("mem_request", 80'(held_req), 80'(req_q.pop_front()));
      end else if (mem_req_o) begin
        chk("mem_stable", 80'({mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o}), 80'(held_req));
      end
      if (stallreq_o) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (lat_q.size() == 0) chk("lat_q_underflow", 80'd1, 80'd0);
        else chk("stall_len", 80'(stall_cnt), 80'(lat_q.pop_front()));
        stall_cnt = 0;
      end
      prev_done = mem_req_o && mem_ack_i;
      prev_req = mem_req_o;
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Main stimulus
  initial begin
    rst = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    #2;
    chk("rst_cpu_data", 80'(cpu_data_o), 80'd0);
    chk("rst_mem_req", 80'(mem_req_o), 80'd0);
    chk("rst_stall", 80'(stallreq_o), 80'd0);
    chk("rst_mem_regs", 80'({mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o}), 80'd0);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    chk("rst_bus_err", 80'(bus_err_o), 80'd0);
`endif
    #6 rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // Load, ack on the third cycle after the request is seen: 4 stall cycles.
    do_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 2, 32'h1234_5678, -1);
    // Store with immediate ack; returned data must not change cpu_data_o.
    do_txn(1'b1, 32'h0000_0020, 4'b0011, 32'hAABB_CCDD, 0, 32'h5555_5555, -1);
    // Back-to-back loads.
    do_txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 0, 32'h0000_0001, -1);
    do_txn(1'b0, 32'h0000_0104, 4'hF, 32'h0, 0, 32'h0000_0002, -1);
    // Flush during REQ: result discarded.
    do_txn(1'b0, 32'h0000_0200, 4'hF, 32'h0, 2, 32'hFFFF_FFFF, 1);
    // Flush on the ack cycle itself.
    do_txn(1'b0, 32'h0000_0204, 4'hF, 32'h0, 1, 32'hFFFF_0000, 1);

    for (int k = 0; k < 40; k++) begin
      int w;
      int fa;
      w = $urandom_range(0, 5);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
      do_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
             w, $urandom, fa);
    end

    tick(); tick();
    chk("req_q_drained", 80'(req_q.size()), 80'd0);
    chk("exp_q_drained", 80'(exp_q.size()), 80'd0);
    chk("lat_q_drained", 80'(lat_q.size()), 80'd0);
    mon_en = 1'b0;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // No ack: after TB_TIMEOUT REQ cycles the watchdog completes the load.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    repeat (TB_TIMEOUT - 1) tick();
    chk("to_still_waiting", 80'(mem_req_o), 80'd1);
    tick();
    chk("to_data", 80'(cpu_data_o), 80'(32'hDEAD_BEEF));
    chk("to_bus_err", 80'(bus_err_o), 80'd1);
    chk("to_req_drop", 80'(mem_req_o), 80'd0);
    repeat (3) tick();
    chk("to_bus_err_sticky", 80'(bus_err_o), 80'd1);
`endif

    // Reset asserted between edges in the middle of REQ.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    #2;
    chk("pre_rst_req", 80'(mem_req_o), 80'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_req", 80'(mem_req_o), 80'd0);
    chk("async_rst_stall", 80'(stallreq_o), 80'd0);
    chk("async_rst_data", 80'(cpu_data_o), 80'd0);
    chk("async_rst_addr", 80'(mem_addr_o), 80'd0);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    chk("async_rst_bus_err", 80'(bus_err_o), 80'd0);
`endif
    #4 rst = 1'b1;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk("stray_ack_req", 80'(mem_req_o), 80'd0);
    chk("stray_ack_stall", 80'(stallreq_o), 80'd0);
    chk("stray_ack_data", 80'(cpu_data_o), 80'd0);

    // A fresh load still works after the reset.
    model_data = 32'd0;
    mon_en = 1'b1;
    do_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 1, 32'h0BAD_F00D, -1);
    tick(); tick();
    chk("final_q_drained", 80'(exp_q.size() + req_q.size() + lat_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
